// File: rtl/cnn_pkg.sv
// Shared types for the CNN activation and dense-layer datapaths.
//   act_mode_e  : activation selected for a pass (2-bit encoding matches the mode port)
//   act_state_e : sequencing states of the in-place activation pass
package cnn_pkg;

    typedef enum logic [1:0] {
        ACT_RELU   = 2'd0,
        ACT_LEAKY  = 2'd1,
        ACT_CLIP   = 2'd2,
        ACT_BYPASS = 2'd3
    } act_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } act_state_e;

endpackage

// File: rtl/act_func.sv
// Combinational activation function y = f(x, mode) on signed fixed-point data.
// Shared with the dense-layer path, so it carries no state.
//   i_x    : signed input element
//   i_mode : ReLU / leaky / clip / bypass
//   o_y    : activated element, same width as i_x
module act_func
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LEAK_SHIFT = 3,
    parameter int CLIP_MAX   = 768
) (
    input  logic signed [DATA_WIDTH-1:0] i_x,
    input  act_mode_e                    i_mode,
    output logic signed [DATA_WIDTH-1:0] o_y
);

    localparam logic signed [DATA_WIDTH-1:0] C_CLIP = DATA_WIDTH'(CLIP_MAX);

    logic w_neg;
    assign w_neg = i_x[DATA_WIDTH-1];

    always_comb begin
        o_y = i_x;
        case (i_mode)
            ACT_RELU: begin
                if (w_neg) o_y = '0;
            end
            ACT_LEAKY: begin
                // Arithmetic shift floors toward -inf, so small negatives settle at -1.
                if (w_neg) o_y = i_x >>> LEAK_SHIFT;
            end
            ACT_CLIP: begin
                if (w_neg)
                    o_y = '0;
                else if (i_x > C_CLIP)
                    o_y = C_CLIP;
            end
            default: o_y = i_x;
        endcase
    end

endmodule

// File: rtl/relu_act_pipe.sv
// In-place activation pass over a CHANNELS x IMG_SIZE x IMG_SIZE conv buffer.
// Element i is read on port A, activated, and written back on port B two cycles
// later at one element per cycle.
// Build option: define ACT_STATS_EN to add the neg_count port and counter.
// Ports:
//   clk, reset_n              : clock, asynchronous active-low reset
//   start, mode               : 1-cycle start pulse, activation mode sampled with it
//   busy, done                : pass in progress, 1-cycle completion pulse
//   conv_r_addr/_en, conv_r_q : sync-read port, data valid the cycle after en
//   conv_w_addr/_en/_we/_d    : write port
//   neg_count                 : (ACT_STATS_EN) negative inputs seen in the last pass
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing reads 0..N-1
// DRAIN | reads done, waiting for the last write
// FIN   | done pulse, back to IDLE next cycle
module relu_act_pipe
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 7,
    parameter int CHANNELS   = 1,
    parameter int IMG_SIZE   = 28,
    parameter int LEAK_SHIFT = 3,
    parameter int CLIP_MAX   = 6 << FRAC_BITS,
    localparam int N  = CHANNELS * IMG_SIZE * IMG_SIZE,
    localparam int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    output logic                  busy,
    output logic [AW-1:0]         conv_r_addr,
    output logic                  conv_r_en,
    input  logic [DATA_WIDTH-1:0] conv_r_q,
    output logic [AW-1:0]         conv_w_addr,
    output logic                  conv_w_en,
    output logic                  conv_w_we,
    output logic [DATA_WIDTH-1:0] conv_w_d,
    output logic                  done
`ifdef ACT_STATS_EN
    ,
    output logic [AW:0]           neg_count
`endif
);

    localparam logic [AW-1:0] C_LAST = AW'(N - 1);

    act_state_e              r_state;
    act_mode_e               r_mode;
    logic                    r_v1;
    logic [AW-1:0]           r_a1;
    logic                    w_start_acc;
    logic signed [DATA_WIDTH-1:0] w_y;

    assign w_start_acc = start && (r_state == IDLE);
    assign conv_w_we   = conv_w_en;

    act_func #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEAK_SHIFT (LEAK_SHIFT),
        .CLIP_MAX   (CLIP_MAX)
    ) u_act_func (
        .i_x    ($signed(conv_r_q)),
        .i_mode (r_mode),
        .o_y    (w_y)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_mode      <= ACT_RELU;
            r_v1        <= 1'b0;
            r_a1        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            conv_r_en   <= 1'b0;
            conv_r_addr <= '0;
            conv_w_en   <= 1'b0;
            conv_w_addr <= '0;
            conv_w_d    <= '0;
        end else begin
            // Stage 1 tracks which address the returning read data belongs to;
            // stage 2 is the registered write-back.
            r_v1      <= conv_r_en;
            r_a1      <= conv_r_addr;
            conv_w_en <= r_v1;
            if (r_v1) begin
                conv_w_addr <= r_a1;
                conv_w_d    <= w_y;
            end
            done <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_start_acc) begin
                        r_mode <= act_mode_e'(mode);
                        busy   <= 1'b1;
                        if (act_mode_e'(mode) == ACT_BYPASS) begin
                            r_state <= FIN;
                            done    <= 1'b1;
                        end else begin
                            r_state     <= RUN;
                            conv_r_en   <= 1'b1;
                            conv_r_addr <= '0;
                        end
                    end
                end
                RUN: begin
                    if (conv_r_addr == C_LAST) begin
                        conv_r_en <= 1'b0;
                        r_state   <= DRAIN;
                    end else begin
                        conv_r_addr <= conv_r_addr + AW'(1);
                    end
                end
                DRAIN: begin
                    if (conv_w_en && (conv_w_addr == C_LAST)) begin
                        r_state <= FIN;
                        done    <= 1'b1;
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ACT_STATS_EN
    // Counts at stage 1, where the raw input element is visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            neg_count <= '0;
        else if (w_start_acc)
            neg_count <= '0;
        else if (r_v1 && conv_r_q[DATA_WIDTH-1])
            neg_count <= neg_count + (AW + 1)'(1);
    end
`endif

endmodule

// File: tb/tb_relu_act_pipe.sv
module tb_relu_act_pipe;

    localparam int DW    = 16;
    localparam int N     = 64;
    localparam int AW    = 6;
    localparam int CLIPV = 768;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [1:0]    mode;
    logic          busy;
    logic [AW-1:0] conv_r_addr;
    logic          conv_r_en;
    logic [DW-1:0] conv_r_q;
    logic [AW-1:0] conv_w_addr;
    logic          conv_w_en;
    logic          conv_w_we;
    logic [DW-1:0] conv_w_d;
    logic          done;
`ifdef ACT_STATS_EN
    logic [AW:0]   neg_count;
`endif

    relu_act_pipe #(
        .DATA_WIDTH (16),
        .FRAC_BITS  (7),
        .CHANNELS   (1),
        .IMG_SIZE   (8),
        .LEAK_SHIFT (3)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .mode        (mode),
        .busy        (busy),
        .conv_r_addr (conv_r_addr),
        .conv_r_en   (conv_r_en),
        .conv_r_q    (conv_r_q),
        .conv_w_addr (conv_w_addr),
        .conv_w_en   (conv_w_en),
        .conv_w_we   (conv_w_we),
        .conv_w_d    (conv_w_d),
        .done        (done)
`ifdef ACT_STATS_EN
        ,
        .neg_count   (neg_count)
`endif
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int t_start = 0;
    int lat = 0;
    bit track = 0;
    bit traffic = 0;
    bit done_seen = 0;
    bit ld_all = 0;

    logic signed [DW-1:0] mem [N];
    logic signed [DW-1:0] img [N];
    int exp_mem [N];
    int q_addr [$];
    int q_data [$];

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Dual-port RAM model, 1-cycle synchronous read.
    always @(posedge clk) begin
        if (ld_all)
            for (int k = 0; k < N; k++) mem[k] = img[k];
        if (conv_w_en && conv_w_we) mem[conv_w_addr] = conv_w_d;
        if (conv_r_en) conv_r_q <= mem[conv_r_addr];
    end

    task automatic chk_eq(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int f_ref(input int x, input int m);
        if (m == 3) return x;
        if (x >= 0) return (m == 2 && x > CLIPV) ? CLIPV : x;
        if (m == 1) return (x - 7) / 8;  // floor(x/8) for negative x
        return 0;
    endfunction

    // Monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        int d, ea, ed;
        d = cyc - t_start;
        if (track) begin
            chk_eq("busy", int'(busy), int'(d >= 1 && d <= lat));
            if (conv_r_en) begin
                chk_eq("rd_window", int'(traffic && d >= 1 && d <= N), 1);
                chk_eq("rd_addr", int'(conv_r_addr), d - 1);
            end
            if (conv_w_en) begin
                chk_eq("wr_we", int'(conv_w_we), 1);
                if (q_addr.size() == 0) begin
                    chk_eq("wr_extra", 1, 0);
                end else begin
                    ea = q_addr.pop_front();
                    ed = q_data.pop_front();
                    chk_eq("wr_addr", int'(conv_w_addr), ea);
                    chk_eq("wr_data", int'($signed(conv_w_d)), ed);
                    chk_eq("wr_time", d, ea + 3);
                end
            end else if (conv_w_we) begin
                chk_eq("wr_we_idle", 1, 0);
            end
            if (done) begin
                chk_eq("done_time", d, lat);
                done_seen = 1;
            end
        end else if (conv_r_en || conv_w_en || conv_w_we || done) begin
            chk_eq("idle_traffic", 1, 0);
        end
    end

    task automatic load();
        ld_all = 1;
        @(posedge clk); #1;
        ld_all = 0;
    endtask

    task automatic do_start(input int m);
        int e;
        track   = 0;
        mode    = 2'(m);
        lat     = (m == 3) ? 1 : N + 3;
        traffic = (m != 3);
        q_addr.delete();
        q_data.delete();
        for (int i = 0; i < N; i++) begin
            e = f_ref(int'(mem[i]), m);
            exp_mem[i] = e;
            if (traffic) begin
                q_addr.push_back(i);
                q_data.push_back(e);
            end
        end
        done_seen = 0;
        start = 1;
        @(posedge clk); #1;
        start   = 0;
        t_start = cyc - 1;
        track   = 1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc - t_start < n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < N + 20 && !done_seen; k++) begin
            @(posedge clk); #1;
        end
        chk_eq({tag, "_done"}, int'(done_seen), 1);
        chk_eq({tag, "_sb_empty"}, q_addr.size(), 0);
    endtask

    task automatic chk_mem(input string tag);
        int ne;
        ne = 0;
        for (int i = 0; i < N; i++)
            if (int'(mem[i]) != exp_mem[i]) ne++;
        chk_eq({tag, "_mem"}, ne, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk_eq({tag, "_busy"}, int'(busy), 0);
        chk_eq({tag, "_r_en"}, int'(conv_r_en), 0);
        chk_eq({tag, "_r_addr"}, int'(conv_r_addr), 0);
        chk_eq({tag, "_w_en"}, int'(conv_w_en), 0);
        chk_eq({tag, "_w_we"}, int'(conv_w_we), 0);
        chk_eq({tag, "_w_addr"}, int'(conv_w_addr), 0);
        chk_eq({tag, "_w_d"}, int'(conv_w_d), 0);
        chk_eq({tag, "_done"}, int'(done), 0);
`ifdef ACT_STATS_EN
        chk_eq({tag, "_neg_count"}, int'(neg_count), 0);
`endif
    endtask

    task automatic fill_pat1();
        for (int i = 0; i < N; i++)
            img[i] = (i % 3 == 0) ? DW'(-i) : (i % 3 == 1) ? DW'(0) : DW'(i);
    endtask

    initial begin
        start   = 0;
        mode    = 0;
        reset_n = 1;
        #1 reset_n = 0;
        #2 chk_zero("rst");
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        @(posedge clk); #1;

        // ReLU
        fill_pat1();
        load();
        do_start(0);
        wait_done("relu");
        chk_mem("relu");
`ifdef ACT_STATS_EN
        chk_eq("neg_count_relu", int'(neg_count), 21);
`endif
        // Rerun on the already rectified buffer
        do_start(0);
        wait_done("relu2");
        chk_mem("relu2");
`ifdef ACT_STATS_EN
        chk_eq("neg_count_rerun", int'(neg_count), 0);
`endif

        // Leaky, with a start pulse landing in the done cycle
        for (int i = 0; i < N; i++) img[i] = DW'(i * 5);
        img[3] = -24; img[6] = -1; img[9] = -7; img[12] = -32768; img[15] = -9;
        load();
        do_start(1);
        wait_cyc(N + 3);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        wait_done("leaky");
        chk_mem("leaky");
        chk_eq("leaky_m3", int'(mem[3]), -3);
        chk_eq("leaky_m6", int'(mem[6]), -1);
        chk_eq("leaky_m9", int'(mem[9]), -1);
        repeat (3) begin @(posedge clk); #1; end

        // Clip, then bypass in the cycle right after done
        for (int i = 0; i < N; i++) img[i] = DW'(i * 13 - 200);
        img[0] = -5; img[1] = 700; img[2] = 768; img[3] = 1000;
        img[4] = 769; img[5] = 32767; img[6] = -32768;
        load();
        do_start(2);
        wait_done("clip");
        chk_mem("clip");
        chk_eq("clip_m3", int'(mem[3]), 768);
        do_start(3);
        wait_done("bypass");
        chk_mem("bypass");
`ifdef ACT_STATS_EN
        chk_eq("neg_count_bypass", int'(neg_count), 0);
`endif
        repeat (4) begin @(posedge clk); #1; end

        // Ignored start / mode flip, then abort by reset
        fill_pat1();
        load();
        do_start(0);
        wait_cyc(5);
        mode = 2'd1;
        wait_cyc(10);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        wait_cyc(20);
        track   = 0;
        reset_n = 0;
        #1 chk_zero("abort");
        repeat (3) begin @(posedge clk); #1; end
        chk_eq("abort_no_done", int'(done_seen), 0);
        reset_n = 1;
        q_addr.delete();
        q_data.delete();
        @(posedge clk); #1;

        load();
        do_start(0);
        wait_done("after_abort");
        chk_mem("after_abort");
`ifdef ACT_STATS_EN
        chk_eq("neg_count_after_abort", int'(neg_count), 21);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
